// File: rtl/pwconv_pkg.sv
// Shared types and constants for the pointwise-conv bias scheduler.
// FSM state encoding plus the saturation bounds of the default datapath width.
package pwconv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        BREQ,
        BWAIT,
        OUT,
        FIN
    } pw_state_t;

    localparam int DATA_W_DEF = 32;

    localparam logic [DATA_W_DEF-1:0] SAT_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic [DATA_W_DEF-1:0] SAT_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/pwconv_bias_sat_add.sv
// Signed accumulator + bias add, clamped to the DATA_W signed range.
// Purely combinational; the caller registers the result.
import pwconv_pkg::*;

module pwconv_bias_sat_add #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] y
);

    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] sum;

    assign sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};

    // The two top bits of the widened sum disagree only on overflow.
    always_comb begin
        y = sum[DATA_W-1:0];
        if (sum[DATA_W] != sum[DATA_W-1]) begin
            y = sum[DATA_W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/pwconv_bias_scheduler.sv
// Per-output-channel sequencer for one pointwise-conv layer: gates MAC steps,
// fetches the channel bias from ROM, saturating-adds it and hands it downstream.
import pwconv_pkg::*;

module pwconv_bias_scheduler #(
    parameter int NUM_OCH = 32,
    parameter int NUM_ICH = 16,
    parameter int ADR_W   = 5,
    parameter int ICH_W   = 4,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     act_valid,
    output logic                     act_ready,
    output logic                     mac_en,
    output logic                     mac_clr,
    output logic [ICH_W-1:0]         ich_idx,
    output logic [ADR_W-1:0]         och_idx,
    output logic                     rom_me,
    output logic [ADR_W-1:0]         rom_adr,
    input  logic signed [DATA_W-1:0] rom_q,
    input  logic signed [DATA_W-1:0] acc_in,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [ADR_W-1:0] OCH_LAST = ADR_W'(NUM_OCH - 1);
    localparam logic [ICH_W-1:0] ICH_LAST = ICH_W'(NUM_ICH - 1);

    pw_state_t               state;
    logic [ADR_W-1:0]        och;
    logic [ICH_W-1:0]        ich;
    logic signed [DATA_W-1:0] sum_sat;

    // The MAC handshake is combinational so a step can be taken every cycle.
    assign mac_en    = (state == MAC) && act_valid;
    assign act_ready = mac_en;
    assign mac_clr   = mac_en && (ich == '0);
    assign ich_idx   = ich;
    assign och_idx   = och;

    pwconv_bias_sat_add #(
        .DATA_W(DATA_W)
    ) u_sat_add (
        .a(acc_in),
        .b(rom_q),
        .y(sum_sat)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            och       <= '0;
            ich       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rom_me    <= 1'b0;
            rom_adr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            done    <= 1'b0;
            rom_me  <= 1'b0;
            rom_adr <= '0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= MAC;
                        och   <= '0;
                        ich   <= '0;
                        busy  <= 1'b1;
                    end
                end
                MAC: begin
                    if (act_valid) begin
                        if (ich == ICH_LAST) begin
                            ich     <= '0;
                            rom_me  <= 1'b1;
                            rom_adr <= och;
                            state   <= BREQ;
                        end else begin
                            ich <= ich + ICH_W'(1);
                        end
                    end
                end
                BREQ: begin
                    state <= BWAIT;
                end
                // ROM data and final accumulator are both valid here.
                BWAIT: begin
                    out_data  <= sum_sat;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (och == OCH_LAST) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            och   <= och + ADR_W'(1);
                            state <= MAC;
                        end
                    end
                end
                FIN: begin
                    och   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwconv_bias_scheduler.sv
// Directed bench for pwconv_bias_scheduler with ROM and MAC-array models
// and an output scoreboard fed from the per-layer stimulus tables.
import pwconv_pkg::*;

module tb_pwconv_bias_scheduler;

    localparam int NO = 4;
    localparam int NI = 3;
    localparam int AW = 2;
    localparam int IW = 2;
    localparam int DW = 32;

    logic          clk;
    logic          rst_b;
    logic          start;
    logic          busy;
    logic          done;
    logic          act_valid;
    logic          act_ready;
    logic          mac_en;
    logic          mac_clr;
    logic [IW-1:0] ich_idx;
    logic [AW-1:0] och_idx;
    logic          rom_me;
    logic [AW-1:0] rom_adr;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] acc_in;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    logic [DW-1:0] act_tab [NO*NI];
    logic [DW-1:0] bias_tab[NO];
    logic [DW-1:0] act_data;
    logic [DW-1:0] acc;
    logic [DW-1:0] exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    int base = 0;
    int exp_och = 0;
    int mac_in_ch = 0;
    int rom_in_ch = 0;
    int busy_cyc = 0;
    bit got_done = 0;
    bit act_rand = 0;

    pwconv_bias_scheduler #(
        .NUM_OCH(NO),
        .NUM_ICH(NI),
        .ADR_W(AW),
        .ICH_W(IW),
        .DATA_W(DW)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .start(start),
        .busy(busy),
        .done(done),
        .act_valid(act_valid),
        .act_ready(act_ready),
        .mac_en(mac_en),
        .mac_clr(mac_clr),
        .ich_idx(ich_idx),
        .och_idx(och_idx),
        .rom_me(rom_me),
        .rom_adr(rom_adr),
        .rom_q(rom_q),
        .acc_in(acc_in),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: q is only meaningful the cycle after rom_me, garbage otherwise.
    always @(posedge clk) begin
        rom_q <= rom_me ? bias_tab[rom_adr] : $urandom();
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) acc <= '0;
        else if (mac_en) acc <= mac_clr ? act_data : acc + act_data;
    end
    assign acc_in = acc;

    always @(posedge clk) begin
        if (act_valid && act_ready) hs_cnt <= hs_cnt + 1;
    end

    always_comb begin
        act_data = '0;
        if (hs_cnt >= base && hs_cnt - base < NO*NI) act_data = act_tab[hs_cnt - base];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_out(input int ch);
        logic [DW-1:0] s;
        longint t;
        s = '0;
        for (int i = 0; i < NI; i++) s += act_tab[ch*NI + i];
        t = longint'($signed(s)) + longint'($signed(bias_tab[ch]));
        if (t > longint'($signed(SAT_MAX))) return SAT_MAX;
        if (t < longint'($signed(SAT_MIN))) return SAT_MIN;
        return t[DW-1:0];
    endfunction

    task automatic check();
        logic [DW-1:0] e;
        #1;
        if (mac_en) begin
            chk("mac_clr", 64'(mac_clr), 64'(mac_in_ch == 0));
            chk("ich_idx", 64'(ich_idx), 64'(mac_in_ch));
            chk("och_idx", 64'(och_idx), 64'(exp_och));
            mac_in_ch++;
        end
        if (rom_me) begin
            chk("rom_adr", 64'(rom_adr), 64'(exp_och));
            chk("mac_per_ch", 64'(mac_in_ch), 64'(NI));
            mac_in_ch = 0;
            rom_in_ch++;
        end
        if (out_valid && out_ready) begin
            chk("rom_per_ch", 64'(rom_in_ch), 64'd1);
            rom_in_ch = 0;
            chk("sb_extra", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", 64'(out_data), 64'(e));
            end
            exp_och++;
        end
        if (done) got_done = 1;
        else if (busy) busy_cyc++;
    endtask

    task automatic advance();
        @(negedge clk);
        if (act_rand) act_valid = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        check();
        advance();
    endtask

    task automatic start_layer();
        base = hs_cnt;
        exp_och = 0;
        mac_in_ch = 0;
        rom_in_ch = 0;
        got_done = 0;
        busy_cyc = 0;
        for (int c = 0; c < NO; c++) exp_q.push_back(ref_out(c));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input bit start_in_fin);
        for (int k = 0; k < 400 && !got_done; k++) begin
            check();
            if (got_done) start = start_in_fin;
            advance();
        end
        start = 1'b0;
        chk("done_seen", 64'(got_done), 64'd1);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic idle_check();
        check();
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        advance();
    endtask

    task automatic set_basic();
        for (int c = 0; c < NO; c++) begin
            bias_tab[c] = DW'(10 * c);
            act_tab[c*NI + 0] = DW'(50 + c);
            act_tab[c*NI + 1] = DW'(30 - c);
            act_tab[c*NI + 2] = DW'(20);
        end
    endtask

    initial begin
        logic [DW-1:0] held;
        bit hit;
        rst_b = 1'b0;
        start = 1'b0;
        act_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NO*NI; i++) act_tab[i] = '0;
        for (int c = 0; c < NO; c++) bias_tab[c] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_rom_me", 64'(rom_me), 64'd0);
        chk("rst_och", 64'(och_idx), 64'd0);
        chk("rst_ich", 64'(ich_idx), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        act_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // basic: outputs 100,110,120,130, 24 busy cycles before done
        set_basic();
        start_layer();
        run_to_done(1'b0);
        chk("basic_cycles", 64'(busy_cyc), 64'd24);
        idle_check();

        // saturation corners; start is also held during FIN
        act_tab[0] = 32'h7FFF_FFF0; act_tab[1] = '0; act_tab[2] = '0;
        bias_tab[0] = 32'h0000_0020;
        act_tab[3] = 32'h8000_0000; act_tab[4] = '0; act_tab[5] = '0;
        bias_tab[1] = 32'hFFFF_FFFF;
        act_tab[6] = 32'hFFFF_FFFB; act_tab[7] = '0; act_tab[8] = '0;
        bias_tab[2] = 32'h0000_0003;
        act_tab[9] = 32'd1; act_tab[10] = 32'd2; act_tab[11] = 32'd3;
        bias_tab[3] = 32'h7FFF_FFFA;
        start_layer();
        run_to_done(1'b1);
        idle_check();
        idle_check();

        // stalls on both sides plus start while busy
        for (int i = 0; i < NO*NI; i++) act_tab[i] = $urandom();
        for (int c = 0; c < NO; c++) bias_tab[c] = DW'($urandom_range(0, 1000)) - 32'd500;
        act_rand = 1'b1;
        out_ready = 1'b0;
        start_layer();
        for (int k = 0; k < 200 && !out_valid; k++) tick();
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        held = out_data;
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(held));
            chk("hold_rom_me", 64'(rom_me), 64'd0);
            chk("hold_och", 64'(och_idx), 64'd0);
            advance();
            start = 1'b0;
        end
        out_ready = 1'b1;
        run_to_done(1'b0);
        act_rand = 1'b0;
        act_valid = 1'b1;
        idle_check();

        // async reset during channel 2 MAC, then a full fresh layer
        set_basic();
        start_layer();
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            check();
            hit = (och_idx == 2) && mac_en;
            if (!hit) advance();
        end
        chk("reset_reach", 64'(hit), 64'd1);
        #2 rst_b = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_mac_en", 64'(mac_en), 64'd0);
        chk("arst_act_ready", 64'(act_ready), 64'd0);
        chk("arst_och", 64'(och_idx), 64'd0);
        chk("arst_ich", 64'(ich_idx), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_rom_me", 64'(rom_me), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        exp_q.delete();
        @(negedge clk);
        start_layer();
        run_to_done(1'b0);
        chk("post_reset_cycles", 64'(busy_cyc), 64'd24);
        idle_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
